// File: rtl/div_req_ctrl.sv
// div_req_ctrl: issue-side divide controller with local handling of RISC-V divide special cases
module div_req_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_rd,
  output logic        div_in_valid,
  input  logic        div_in_ready,
  output logic        div_in_sign,
  output logic [31:0] div_in_a,
  output logic [31:0] div_in_b,
  output logic        div_flush,
  input  logic        div_out_valid,
  output logic        div_out_ready,
  input  logic [31:0] div_out_quot,
  input  logic [31:0] div_out_rem,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;
  logic rem_sel, accept, special, div_zero;
  logic [31:0] spec_res;
  assign div_flush = flush;
  assign accept    = (state == IDLE) & in_valid & ~flush;
  assign div_zero  = in_b == '0;
  assign special   = div_zero | (~in_op[0] & (in_a == 32'h8000_0000) & (in_b == 32'hFFFF_FFFF));
  assign spec_res  = div_zero ? (in_op[1] ? in_a : 32'hFFFF_FFFF) : (in_op[1] ? 32'h0 : 32'h8000_0000);
  // state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // next state: flush overrides every transition
  always_comb begin
    state_nxt = flush            ? IDLE :
                state == IDLE    ? (in_valid ? (special ? DONE : ISSUE) : IDLE) :
                state == ISSUE   ? (div_in_ready ? WAIT : ISSUE) :
                state == WAIT    ? (div_out_valid ? DONE : WAIT) :
                                   (out_ready ? IDLE : DONE);
  end
  // handshake outputs decoded purely from state
  always_comb begin
    in_ready      = state == IDLE;
    div_in_valid  = state == ISSUE;
    div_out_ready = state == WAIT;
    out_valid     = state == DONE;
  end
  // operand latch at accept; result from special-case logic or divider capture
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      div_in_a    <= '0;
      div_in_b    <= '0;
      div_in_sign <= 1'b0;
      rem_sel     <= 1'b0;
      out_rd      <= '0;
      out_data    <= '0;
    end else if (accept) begin
      div_in_a    <= in_a;
      div_in_b    <= in_b;
      div_in_sign <= ~in_op[0];
      rem_sel     <= in_op[1];
      out_rd      <= in_rd;
      if (special) out_data <= spec_res;
    end else if (div_out_ready & div_out_valid & ~flush) begin
      out_data <= rem_sel ? div_out_rem : div_out_quot;
    end
endmodule

// File: tb/tb_div_req_ctrl.sv
// tb_div_req_ctrl: scoreboard bench with an ideal/random-latency divider model and a reference result model
module tb_div_req_ctrl;
  logic clock = 1'b0, reset = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [1:0] in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [4:0] in_rd = '0;
  logic div_in_valid, div_in_ready = 1'b0, div_in_sign, div_flush;
  logic [31:0] div_in_a, div_in_b;
  logic div_out_valid = 1'b0, div_out_ready;
  logic [31:0] div_out_quot = '0, div_out_rem = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0] out_rd;

  div_req_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .div_in_valid(div_in_valid), .div_in_ready(div_in_ready), .div_in_sign(div_in_sign),
    .div_in_a(div_in_a), .div_in_b(div_in_b), .div_flush(div_flush),
    .div_out_valid(div_out_valid), .div_out_ready(div_out_ready),
    .div_out_quot(div_out_quot), .div_out_rem(div_out_rem),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  logic [36:0] sb[$];
  logic fast = 1'b1, in_stall = 1'b0, rand_or = 1'b0, or_force = 1'b1;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // architectural result straight from the ISA rules
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = 0; end
    else if (!op[0]) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else begin q = a / b; r = a % b; end
    return op[1] ? r : q;
  endfunction

  // divider model: computes from what the DUT actually sends; garbage for cases it should never see
  logic busy = 1'b0;
  int dly = 0;
  logic [31:0] pq = '0, pr = '0;
  always @(posedge clock) begin
    if (!reset || flush) busy = 1'b0;
    else if (busy) begin
      if (div_out_valid && div_out_ready) busy = 1'b0;
      else if (dly > 0) dly--;
    end else if (div_in_valid && div_in_ready) begin
      busy = 1'b1;
      dly = fast ? 0 : int'($urandom_range(0, 3));
      if (div_in_b == 0 || (div_in_sign && div_in_a == 32'h8000_0000 && div_in_b == 32'hFFFF_FFFF)) begin
        pq = 32'hDEAD_BEEF; pr = 32'hDEAD_BEEF;
      end else if (div_in_sign) begin
        pq = $signed(div_in_a) / $signed(div_in_b); pr = $signed(div_in_a) % $signed(div_in_b);
      end else begin
        pq = div_in_a / div_in_b; pr = div_in_a % div_in_b;
      end
    end
    #1;
    div_in_ready  = !busy && !in_stall && (fast || $urandom_range(0, 2) != 0);
    div_out_valid = busy && dly == 0;
    div_out_quot  = div_out_valid ? pq : $urandom;
    div_out_rem   = div_out_valid ? pr : $urandom;
    out_ready     = rand_or ? 1'($urandom_range(0, 1)) : or_force;
  end

  // monitor: every writeback handshake pops and checks one expected result
  always @(negedge clock)
    if (reset && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) chk("out_unexpected", 72'(out_valid), 72'd0);
      else chk("out_data_rd", 72'({out_data, out_rd}), 72'(sb.pop_front()));
    end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input bit push);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    do begin @(posedge clock); n++; end while (!in_ready && n < 200);
    chk("accept", 72'(in_ready), 72'd1);
    if (push) sb.push_back({ref_res(op, a, b), rd});
    #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clock); n++; end
    chk("out_valid_seen", 72'(out_valid), 72'd1);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, input bit special, input bit sign);
    int n;
    send(op, a, b, rd, 1'b1);
    @(negedge clock);
    chk("div_in_valid", 72'(div_in_valid), 72'(!special));
    if (!special) chk("div_in_sign", 72'(div_in_sign), 72'(sign));
    wait_out(n);
    chk("latency", 72'(n), special ? 72'd0 : 72'd2);
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h0;
      2: return 32'($urandom_range(0, 20));
      3: return ~32'($urandom_range(0, 19));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 20));
      3: return ~32'($urandom_range(0, 19));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl", 72'({in_ready, div_in_valid, div_out_ready, out_valid, div_in_sign}), 72'b10000);
    chk("reset_data", 72'({out_data, out_rd, div_in_a}), 72'd0);
    chk("reset_div_b", 72'(div_in_b), 72'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b0, 1'b1);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b0, 1'b1);
    run(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0, 1'b0);
    run(2'b01, 32'd5, 32'd0, 5'd6, 1'b1, 1'b0);
    run(2'b10, 32'd5, 32'd0, 5'd7, 1'b1, 1'b0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1, 1'b0);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0, 1'b0);
    // request under flush in IDLE is ignored
    flush = 1'b1; in_valid = 1'b1; in_op = 2'b01; in_a = 32'd9; in_b = 32'd0; in_rd = 5'd1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("flush_idle_reject", 72'({in_ready, div_in_valid, out_valid}), 72'b100);
    @(posedge clock); #1;
    // flush while waiting on the divider
    send(2'b01, 32'd50, 32'd3, 5'd11, 1'b0);
    @(posedge clock); #1;
    flush = 1'b1;
    @(negedge clock);
    chk("flush_wait", 72'({div_flush, div_out_ready}), 72'b11);
    @(posedge clock); #1;
    flush = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk("flush_discard", 72'({in_ready, out_valid}), 72'b10);
    end
    @(posedge clock); #1;
    run(2'b01, 32'd100, 32'd7, 5'd12, 1'b0, 1'b0);
    // divider request backpressure
    in_stall = 1'b1;
    send(2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd13, 1'b1);
    repeat (3) begin
      @(negedge clock);
      chk("issue_hold", 72'({div_in_valid, div_in_sign, div_in_a, div_in_b}), 72'({1'b1, 1'b1, 32'd1000, 32'hFFFF_FFFD}));
    end
    in_stall = 1'b0;
    wait_out(n);
    @(posedge clock); #1;
    // writeback backpressure
    or_force = 1'b0;
    send(2'b01, 32'd12345, 32'd10, 5'd14, 1'b1);
    @(negedge clock);
    wait_out(n);
    repeat (5) begin
      chk("done_hold", 72'({out_valid, out_data, out_rd, in_ready}), 72'({1'b1, 32'd1234, 5'd14, 1'b0}));
      @(negedge clock);
    end
    or_force = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    // asynchronous reset while holding a result
    or_force = 1'b0;
    send(2'b10, 32'd5, 32'd0, 5'd15, 1'b0);
    @(negedge clock);
    chk("pre_reset_done", 72'(out_valid), 72'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_ctrl", 72'({in_ready, div_in_valid, div_out_ready, out_valid, div_in_sign}), 72'b10000);
    chk("async_reset_data", 72'({out_data, out_rd, div_in_a}), 72'd0);
    chk("async_reset_div_b", 72'(div_in_b), 72'd0);
    @(negedge clock) reset = 1'b1;
    or_force = 1'b1;
    @(posedge clock); #1;
    // randomized traffic with random divider latency and writeback stalls
    fast = 1'b0;
    rand_or = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(2'($urandom), pick_a(), pick_b(), 5'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    n = 0;
    while (sb.size() != 0 && n < 1000) begin @(posedge clock); n++; end
    chk("scoreboard_drained", 72'(sb.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
